// File: rtl/sda_kernel_pkg.sv
// rtl/sda_kernel_pkg.sv - shared widths, state encoding and response helpers for the kernel gmem path
package sda_kernel_pkg;

   localparam int AXI_MASTER_ADDR_WIDTH = 32;
   localparam int AXI_MASTER_DATA_WIDTH = 32;
   localparam int AXI_MASTER_STRB_WIDTH = AXI_MASTER_DATA_WIDTH / 8;
   localparam int AXI_MASTER_ID_WIDTH   = 4;
   localparam int AXI_MASTER_LEN_WIDTH  = 8;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      QUIESCED = 2'd2
   } quiesce_state_e;

   function automatic logic is_err_resp(input logic [1:0] resp);
      return resp != AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/sda_kernel_txn_counter.sv
// rtl/sda_kernel_txn_counter.sv - saturating up/down outstanding-transaction counter
module sda_kernel_txn_counter #(
   parameter int Width  = 8,
   parameter int Max    = 16,
   parameter bit Signed = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             dec,
   output logic [Width-1:0] count,
   output logic             at_max,
   output logic             is_zero,
   output logic             underflow
);

   localparam logic [Width-1:0] MaxVal = Width'(Max);
   localparam logic [Width-1:0] One    = Width'(1);
   // Unsigned counters bottom out at zero; the signed one may go negative down to its most negative value.
   localparam logic [Width-1:0] MinVal = Signed ? {1'b1, {(Width-1){1'b0}}} : '0;

   logic at_min;

   assign at_max    = (count == MaxVal);
   assign is_zero   = (count == '0);
   assign at_min    = (count == MinVal);
   assign underflow = ~Signed & dec & is_zero;

   // Count up/down; simultaneous inc and dec cancel, both ends saturate.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && !at_max) begin
         count <= count + One;
      end else if (dec && !inc && !at_min) begin
         count <= count - One;
      end
   end

endmodule

// File: rtl/sda_kernel_gmem_quiesce.sv
// rtl/sda_kernel_gmem_quiesce.sv - outstanding-burst monitor, cap and drain gate on the kernel gmem master
module sda_kernel_gmem_quiesce
   import sda_kernel_pkg::*;
#(
   parameter int MaxOutstanding = 16,
   parameter int CountWidth     = 8
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst,
   input  logic                             drain_req,
   output logic                             drain_done,
   output logic                             err_unexp,
   output logic                             err_resp,
   output logic [1:0]                       err_code,
   input  logic                             s_AWVALID,
   output logic                             s_AWREADY,
   input  logic [AXI_MASTER_ADDR_WIDTH-1:0] s_AWADDR,
   input  logic [AXI_MASTER_LEN_WIDTH-1:0]  s_AWLEN,
   input  logic [AXI_MASTER_ID_WIDTH-1:0]   s_AWID,
   output logic                             m_AWVALID,
   input  logic                             m_AWREADY,
   output logic [AXI_MASTER_ADDR_WIDTH-1:0] m_AWADDR,
   output logic [AXI_MASTER_LEN_WIDTH-1:0]  m_AWLEN,
   output logic [AXI_MASTER_ID_WIDTH-1:0]   m_AWID,
   input  logic                             s_WVALID,
   output logic                             s_WREADY,
   input  logic [AXI_MASTER_DATA_WIDTH-1:0] s_WDATA,
   input  logic [AXI_MASTER_STRB_WIDTH-1:0] s_WSTRB,
   input  logic                             s_WLAST,
   output logic                             m_WVALID,
   input  logic                             m_WREADY,
   output logic [AXI_MASTER_DATA_WIDTH-1:0] m_WDATA,
   output logic [AXI_MASTER_STRB_WIDTH-1:0] m_WSTRB,
   output logic                             m_WLAST,
   output logic                             s_BVALID,
   input  logic                             s_BREADY,
   output logic [1:0]                       s_BRESP,
   output logic [AXI_MASTER_ID_WIDTH-1:0]   s_BID,
   input  logic                             m_BVALID,
   output logic                             m_BREADY,
   input  logic [1:0]                       m_BRESP,
   input  logic [AXI_MASTER_ID_WIDTH-1:0]   m_BID,
   input  logic                             s_ARVALID,
   output logic                             s_ARREADY,
   input  logic [AXI_MASTER_ADDR_WIDTH-1:0] s_ARADDR,
   input  logic [AXI_MASTER_LEN_WIDTH-1:0]  s_ARLEN,
   input  logic [AXI_MASTER_ID_WIDTH-1:0]   s_ARID,
   output logic                             m_ARVALID,
   input  logic                             m_ARREADY,
   output logic [AXI_MASTER_ADDR_WIDTH-1:0] m_ARADDR,
   output logic [AXI_MASTER_LEN_WIDTH-1:0]  m_ARLEN,
   output logic [AXI_MASTER_ID_WIDTH-1:0]   m_ARID,
   output logic                             s_RVALID,
   input  logic                             s_RREADY,
   output logic [AXI_MASTER_DATA_WIDTH-1:0] s_RDATA,
   output logic [1:0]                       s_RRESP,
   output logic                             s_RLAST,
   output logic [AXI_MASTER_ID_WIDTH-1:0]   s_RID,
   input  logic                             m_RVALID,
   output logic                             m_RREADY,
   input  logic [AXI_MASTER_DATA_WIDTH-1:0] m_RDATA,
   input  logic [1:0]                       m_RRESP,
   input  logic                             m_RLAST,
   input  logic [AXI_MASTER_ID_WIDTH-1:0]   m_RID
);

   quiesce_state_e state_q;

   logic aw_held, ar_held, aw_block, ar_block;
   logic aw_hs, ar_hs, wlast_hs, b_hs, r_hs, rlast_hs;
   logic aw_full, ar_full, w_full;
   logic aw_zero, ar_zero, w_zero, quiet;
   logic aw_unf, ar_unf, w_unf;
   logic [CountWidth-1:0] aw_cnt, ar_cnt;
   logic [CountWidth:0]   w_cnt;
   logic unused_sigs;

   // A held request keeps its valid asserted regardless of cap or drain state.
   assign aw_block = (aw_full | (state_q != RUN)) & ~aw_held;
   assign ar_block = (ar_full | (state_q != RUN)) & ~ar_held;

   assign m_AWVALID = s_AWVALID & ~aw_block;
   assign s_AWREADY = m_AWREADY & ~aw_block;
   assign m_AWADDR  = s_AWADDR;
   assign m_AWLEN   = s_AWLEN;
   assign m_AWID    = s_AWID;

   assign m_ARVALID = s_ARVALID & ~ar_block;
   assign s_ARREADY = m_ARREADY & ~ar_block;
   assign m_ARADDR  = s_ARADDR;
   assign m_ARLEN   = s_ARLEN;
   assign m_ARID    = s_ARID;

   assign m_WVALID = s_WVALID;
   assign s_WREADY = m_WREADY;
   assign m_WDATA  = s_WDATA;
   assign m_WSTRB  = s_WSTRB;
   assign m_WLAST  = s_WLAST;

   assign s_BVALID = m_BVALID;
   assign m_BREADY = s_BREADY;
   assign s_BRESP  = m_BRESP;
   assign s_BID    = m_BID;

   assign s_RVALID = m_RVALID;
   assign m_RREADY = s_RREADY;
   assign s_RDATA  = m_RDATA;
   assign s_RRESP  = m_RRESP;
   assign s_RLAST  = m_RLAST;
   assign s_RID    = m_RID;

   assign aw_hs    = m_AWVALID & m_AWREADY;
   assign ar_hs    = m_ARVALID & m_ARREADY;
   assign wlast_hs = m_WVALID & m_WREADY & m_WLAST;
   assign b_hs     = m_BVALID & m_BREADY;
   assign r_hs     = m_RVALID & m_RREADY;
   assign rlast_hs = r_hs & m_RLAST;

   assign quiet = aw_zero & ar_zero & w_zero & ~aw_held & ~ar_held;

   // Only the flags and the cap compare are consumed; raw counts are kept for observation.
   assign unused_sigs = ^{aw_cnt, ar_cnt, w_cnt, w_full, w_unf};

   sda_kernel_txn_counter #(.Width(CountWidth), .Max(MaxOutstanding), .Signed(1'b0)) u_aw_cnt (
      .clk(ap_clk), .rst(ap_rst), .inc(aw_hs), .dec(b_hs),
      .count(aw_cnt), .at_max(aw_full), .is_zero(aw_zero), .underflow(aw_unf)
   );

   sda_kernel_txn_counter #(.Width(CountWidth), .Max(MaxOutstanding), .Signed(1'b0)) u_ar_cnt (
      .clk(ap_clk), .rst(ap_rst), .inc(ar_hs), .dec(rlast_hs),
      .count(ar_cnt), .at_max(ar_full), .is_zero(ar_zero), .underflow(ar_unf)
   );

   // W may lead AW, so this one is signed and allowed below zero.
   sda_kernel_txn_counter #(.Width(CountWidth+1), .Max((1 << CountWidth) - 1), .Signed(1'b1)) u_w_cnt (
      .clk(ap_clk), .rst(ap_rst), .inc(aw_hs), .dec(wlast_hs),
      .count(w_cnt), .at_max(w_full), .is_zero(w_zero), .underflow(w_unf)
   );

   // Remember requests presented but not yet accepted so they are never withdrawn by the gate.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         aw_held <= 1'b0;
         ar_held <= 1'b0;
      end else begin
         aw_held <= m_AWVALID & ~m_AWREADY;
         ar_held <= m_ARVALID & ~m_ARREADY;
      end
   end

   // Drain state machine; drain_done is registered alongside the state.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= RUN;
         drain_done <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               drain_done <= 1'b0;
               if (drain_req) state_q <= DRAIN;
            end
            DRAIN: begin
               if (!drain_req) begin
                  state_q    <= RUN;
                  drain_done <= 1'b0;
               end else if (quiet) begin
                  state_q    <= QUIESCED;
                  drain_done <= 1'b1;
               end
            end
            QUIESCED: begin
               if (!drain_req) begin
                  state_q    <= RUN;
                  drain_done <= 1'b0;
               end
            end
            default: begin
               state_q    <= RUN;
               drain_done <= 1'b0;
            end
         endcase
      end
   end

   // Sticky error flags; the first bad response code is kept, B taking priority over R.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         err_unexp <= 1'b0;
         err_resp  <= 1'b0;
         err_code  <= AXI_RESP_OKAY;
      end else begin
         if (aw_unf || ar_unf) err_unexp <= 1'b1;
         if (!err_resp) begin
            if (b_hs && is_err_resp(m_BRESP)) begin
               err_resp <= 1'b1;
               err_code <= m_BRESP;
            end else if (r_hs && is_err_resp(m_RRESP)) begin
               err_resp <= 1'b1;
               err_code <= m_RRESP;
            end
         end
      end
   end

endmodule
